mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbiter between an instruction-fetch port and a data port sharing one
// single-port memory with one-cycle synchronous read latency.
module mem_arbiter #(
  parameter int WORD_LEN   = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [WORD_LEN-1:0] i_addr,
  output logic [WORD_LEN-1:0] i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [WORD_LEN-1:0] d_addr,
  input  logic [WORD_LEN-1:0] d_wdata,
  output logic [WORD_LEN-1:0] d_rdata,
  output logic                d_ack,
  output logic [WORD_LEN-1:0] m_addr,
  output logic                m_we,
  output logic [WORD_LEN-1:0] m_wdata,
  input  logic [WORD_LEN-1:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t state, state_next;
  logic   grant;
  logic   pick_d;
  logic   grant_d;
  logic   grant_we;
  logic   last_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Data takes a tie under fixed priority, or when fetch was the last grant.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    pick_d     = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant      = 1'b1;
          pick_d     = d_req && (!i_req || (FIXED_PRIO != 0) || !last_d);
          state_next = ISSUE;
        end
      end
      ISSUE:   state_next = WAIT;
      WAIT:    state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // m_we and the acks default low every cycle, so each is a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_addr   <= '0;
      m_wdata  <= '0;
      m_we     <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
      grant_d  <= 1'b0;
      grant_we <= 1'b0;
      last_d   <= 1'b1;
    end else begin
      m_we  <= 1'b0;
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      if (grant) begin
        m_addr   <= pick_d ? d_addr : i_addr;
        m_wdata  <= pick_d ? d_wdata : '0;
        m_we     <= pick_d && d_we;
        grant_d  <= pick_d;
        grant_we <= pick_d && d_we;
        last_d   <= pick_d;
      end
      if (state == WAIT) begin
        if (!grant_we) begin
          if (grant_d) d_rdata <= m_rdata;
          else         i_rdata <= m_rdata;
        end
        i_ack <= !grant_d;
        d_ack <= grant_d;
      end
      if (state == ACK) begin
        m_addr  <= '0;
        m_wdata <= '0;
      end
    end
  end

endmodule
